counter_push_ctrl: RTL and testbench

Front-end controller for the cascaded three-digit up/down counter. It conditions raw push buttons and produces clean single-cycle up/down command pulses on the counter's 2-bit push input. Conditioning covers synchronisation, debounce, edge detection, hold-to-repeat and a free-running auto-count mode. It sits between the board buttons and the least-significant counter digit; digit carries and display decoding remain downstream.

---
 rtl/counter_push_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_counter_push_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_push_ctrl.sv
// counter_push_ctrl
// Turns raw push buttons into clean single-cycle up/down command pulses
// for the least-significant digit of the cascaded up/down counter.
// Each button is synchronised and debounced. Manual presses give one pulse
// and then auto-repeat while held. A run/stop button toggles a free-running
// auto-count mode.
//
// Ports:
//   i_Clk    system clock, rising edge
//   i_Rst    synchronous reset, active-low
//   i_Btn    raw buttons, active-high: [0] up, [1] down, [2] run/stop
//   o_Push   registered command pulse: [0] increment, [1] decrement
//   o_Run    auto-run mode active
//   o_Dir    auto-run direction: 0 up, 1 down
//   o_State  manual FSM state: 00 IDLE, 01 HOLD, 10 REPEAT
module counter_push_ctrl #(
  parameter int unsigned P_DB_CNT   = 250000,
  parameter int unsigned P_REP_DLY  = 25000000,
  parameter int unsigned P_REP_RATE = 5000000,
  parameter int unsigned P_AUTO_DIV = 50000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [2:0] i_Btn,
  output logic [1:0] o_Push,
  output logic       o_Run,
  output logic       o_Dir,
  output logic [1:0] o_State
);

  localparam int unsigned NBTN    = 3;
  localparam int unsigned BTN_UP  = 0;
  localparam int unsigned BTN_DN  = 1;
  localparam int unsigned BTN_RUN = 2;
  localparam int unsigned DB_W    = $clog2(P_DB_CNT);
  localparam int unsigned REP_MAX = (P_REP_DLY > P_REP_RATE) ? P_REP_DLY : P_REP_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX);
  localparam int unsigned PRE_W   = $clog2(P_AUTO_DIV);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HOLD   = 2'b01,
    ST_REPEAT = 2'b10,
    ST_BAD    = 2'b11
  } state_e;

  logic [NBTN-1:0]  sync1_q, sync2_q;
  logic [NBTN-1:0]  db_q, db_d, db_prev_q;
  logic [DB_W-1:0]  db_cnt_q [NBTN];
  logic [DB_W-1:0]  db_cnt_d [NBTN];
  logic [NBTN-1:0]  rise_c;
  state_e           state_q, state_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             run_q, run_d;
  logic             dir_q, dir_d;
  logic [1:0]       push_q, push_d;
  logic             start_c;

  // Debounce: accept a new level only after P_DB_CNT consecutive disagreeing cycles
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < int'(NBTN); i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(P_DB_CNT - 1)) begin
          db_d[i]     = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  assign rise_c = db_q & ~db_prev_q;

  // Manual FSM, run toggle and auto-run prescaler
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    pre_cnt_d = pre_cnt_q;
    run_d     = run_q;
    dir_d     = dir_q;
    push_d    = 2'b00;
    start_c   = 1'b0;

    // dir_q doubles as the latched button while in HOLD/REPEAT
    case (state_q)
      ST_IDLE: begin
        // a rise while the other button is already high (incl. simultaneous rises) is ignored
        if (rise_c[BTN_UP] && !db_q[BTN_DN]) begin
          start_c   = 1'b1;
          state_d   = ST_HOLD;
          rep_cnt_d = '0;
          dir_d     = 1'b0;
          push_d    = 2'b01;
        end else if (rise_c[BTN_DN] && !db_q[BTN_UP]) begin
          start_c   = 1'b1;
          state_d   = ST_HOLD;
          rep_cnt_d = '0;
          dir_d     = 1'b1;
          push_d    = 2'b10;
        end
      end
      ST_HOLD: begin
        // release wins over a pulse due on the same edge
        if (!db_q[dir_q]) begin
          state_d   = ST_IDLE;
          rep_cnt_d = '0;
        end else if (rep_cnt_q == REP_W'(P_REP_DLY - 1)) begin
          state_d   = ST_REPEAT;
          rep_cnt_d = '0;
          push_d    = dir_q ? 2'b10 : 2'b01;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
      ST_REPEAT: begin
        if (!db_q[dir_q]) begin
          state_d   = ST_IDLE;
          rep_cnt_d = '0;
        end else if (rep_cnt_q == REP_W'(P_REP_RATE - 1)) begin
          rep_cnt_d = '0;
          push_d    = dir_q ? 2'b10 : 2'b01;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rep_cnt_d = '0;
      end
    endcase

    // Toggle edge never pulses; prescaler restarts only when switching on
    if (rise_c[BTN_RUN]) begin
      run_d = ~run_q;
      if (!run_q) begin
        pre_cnt_d = '0;
      end
    end else if (run_q && (state_q == ST_IDLE) && !start_c) begin
      if (pre_cnt_q == PRE_W'(P_AUTO_DIV - 1)) begin
        pre_cnt_d = '0;
        push_d    = dir_q ? 2'b10 : 2'b01;
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < int'(NBTN); i++) begin
        db_cnt_q[i] <= '0;
      end
      state_q   <= ST_IDLE;
      rep_cnt_q <= '0;
      pre_cnt_q <= '0;
      run_q     <= 1'b0;
      dir_q     <= 1'b0;
      push_q    <= 2'b00;
    end else begin
      sync1_q   <= i_Btn;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < int'(NBTN); i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      pre_cnt_q <= pre_cnt_d;
      run_q     <= run_d;
      dir_q     <= dir_d;
      push_q    <= push_d;
    end
  end

  assign o_Push  = push_q;
  assign o_Run   = run_q;
  assign o_Dir   = dir_q;
  assign o_State = state_q;

endmodule

// File: tb/tb_counter_push_ctrl.sv
// tb_counter_push_ctrl
// Bench for counter_push_ctrl with small timing parameters. A behavioural
// model (raw-sample window debounce, elapsed-time repeat schedule, idle-run
// cycle count for auto mode) predicts every output after every edge.
module tb_counter_push_ctrl;

  localparam int DB   = 4;
  localparam int DLY  = 16;
  localparam int RATE = 8;
  localparam int DIV  = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] btn;
  logic [1:0] push;
  logic       run;
  logic       dir;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  counter_push_ctrl #(
    .P_DB_CNT  (DB),
    .P_REP_DLY (DLY),
    .P_REP_RATE(RATE),
    .P_AUTO_DIV(DIV)
  ) dut (
    .i_Clk  (clk),
    .i_Rst  (rst_n),
    .i_Btn  (btn),
    .o_Push (push),
    .o_Run  (run),
    .o_Dir  (dir),
    .o_State(state)
  );

  always #5 clk = ~clk;

  // Reference model state
  int       m_edge = 0;
  bit       m_hist [3][DB+2];
  int       m_since [3];
  bit [2:0] m_db = '0;
  bit [2:0] m_db_prev = '0;
  int       m_mode = 0;
  bit       m_btn = 1'b0;
  int       m_t0 = 0;
  int       m_acnt = 0;
  bit       m_run = 1'b0;
  bit       m_dir = 1'b0;
  bit [1:0] m_push = 2'b00;

  function automatic void model_edge(input bit rst_v, input logic [2:0] raw);
    bit [2:0] rise;
    bit [2:0] db_new;
    bit       was_idle;
    bit       start;
    bit       flip;
    int       el;
    m_edge++;
    m_push = 2'b00;
    if (!rst_v) begin
      for (int b = 0; b < 3; b++) begin
        for (int j = 0; j < DB + 2; j++) m_hist[b][j] = 1'b0;
        m_since[b] = 0;
      end
      m_db = '0; m_db_prev = '0; m_mode = 0; m_run = 1'b0; m_dir = 1'b0; m_acnt = 0;
      return;
    end
    rise   = m_db & ~m_db_prev;
    db_new = m_db;
    // level flips once the synchronised samples (raw two edges back) disagree for DB edges
    for (int b = 0; b < 3; b++) begin
      for (int j = DB + 1; j > 0; j--) m_hist[b][j] = m_hist[b][j-1];
      m_hist[b][0] = raw[b];
      m_since[b]++;
      flip = (m_since[b] >= DB);
      for (int k = 0; k < DB; k++) if (m_hist[b][2+k] == m_db[b]) flip = 1'b0;
      if (flip) begin
        db_new[b]  = ~m_db[b];
        m_since[b] = 0;
      end
    end
    was_idle = (m_mode == 0);
    start    = 1'b0;
    if (m_mode == 0) begin
      if (rise[0] && !m_db[1]) begin start = 1'b1; m_btn = 1'b0; end
      else if (rise[1] && !m_db[0]) begin start = 1'b1; m_btn = 1'b1; end
      if (start) begin
        m_mode = 1; m_t0 = m_edge; m_dir = m_btn;
        m_push = m_btn ? 2'b10 : 2'b01;
      end
    end else if (!m_db[m_btn]) begin
      m_mode = 0;
    end else begin
      el = m_edge - m_t0;
      if (el == DLY || (el > DLY && ((el - DLY) % RATE) == 0)) m_push = m_btn ? 2'b10 : 2'b01;
      m_mode = (el >= DLY) ? 2 : 1;
    end
    if (rise[2]) begin
      if (!m_run) m_acnt = 0;
      m_run = ~m_run;
    end else if (m_run && was_idle && !start) begin
      m_acnt++;
      if ((m_acnt % DIV) == 0) m_push = m_dir ? 2'b10 : 2'b01;
    end
    m_db_prev = m_db;
    m_db      = db_new;
  endfunction

  // Apply inputs for one edge, advance the model, settle past the edge
  task automatic cycle(input bit r, input logic [2:0] b);
    rst_n = r;
    btn   = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 3'($urandom_range(0, 7)));
      checks++;
      if ({push, state, run, dir} !== 6'b0) begin
        errors++;
        $display("FAIL reset k=%0d got push=%b state=%b run=%b dir=%b want all zero", k, push, state, run, dir);
      end
    end
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 3'b000);
      checks++;
      if ({push, state, run, dir} !== {m_push, 2'(m_mode), m_run, m_dir}) begin
        errors++;
        $display("FAIL reset_idle k=%0d got push=%b state=%b run=%b dir=%b want push=%b state=%0d run=%b dir=%b",
                 k, push, state, run, dir, m_push, m_mode, m_run, m_dir);
      end
    end
  endtask

  task automatic test_clean_hold();
    logic [1:0] exp_p, exp_s;
    for (int k = 0; k < 56; k++) begin
      cycle(1'b1, {2'b00, 1'(k < 40)});
      exp_p = (k == 6 || k == 22 || k == 30 || k == 38) ? 2'b01 : 2'b00;
      exp_s = (k < 6) ? 2'b00 : (k < 22) ? 2'b01 : (k < 46) ? 2'b10 : 2'b00;
      checks++;
      if (push !== exp_p || state !== exp_s) begin
        errors++;
        $display("FAIL clean_hold edge %0d got push=%b state=%b want push=%b state=%b", k, push, state, exp_p, exp_s);
      end
      checks++;
      if ({push, state, run, dir} !== {m_push, 2'(m_mode), m_run, m_dir}) begin
        errors++;
        $display("FAIL clean_hold_model edge %0d got push=%b state=%b run=%b dir=%b want push=%b state=%0d run=%b dir=%b",
                 k, push, state, run, dir, m_push, m_mode, m_run, m_dir);
      end
    end
  endtask

  task automatic test_bounce();
    bit pat [20];
    for (int k = 0; k < 20; k++) pat[k] = 1'b0;
    pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, {2'b00, pat[k]});
      checks++;
      if (push !== 2'b00 || state !== 2'b00) begin
        errors++;
        $display("FAIL bounce k=%0d got push=%b state=%b want push=00 state=00", k, push, state);
      end
      checks++;
      if ({push, state, run, dir} !== {m_push, 2'(m_mode), m_run, m_dir}) begin
        errors++;
        $display("FAIL bounce_model k=%0d got push=%b state=%b run=%b dir=%b want push=%b state=%0d run=%b dir=%b",
                 k, push, state, run, dir, m_push, m_mode, m_run, m_dir);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit dir0;
    dir0 = m_dir;
    for (int k = 0; k < 42; k++) begin
      cycle(1'b1, (k < 30) ? 3'b011 : 3'b000);
      checks++;
      if (push !== 2'b00 || state !== 2'b00 || dir !== dir0) begin
        errors++;
        $display("FAIL simultaneous k=%0d got push=%b state=%b dir=%b want push=00 state=00 dir=%b", k, push, state, dir, dir0);
      end
    end
  endtask

  task automatic test_auto_run();
    int npulse;
    // brief down press selects the down direction
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, (k < 8) ? 3'b010 : 3'b000);
      checks++;
      if ({push, state, run, dir} !== {m_push, 2'(m_mode), m_run, m_dir}) begin
        errors++;
        $display("FAIL auto_down k=%0d got push=%b state=%b run=%b dir=%b want push=%b state=%0d run=%b dir=%b",
                 k, push, state, run, dir, m_push, m_mode, m_run, m_dir);
      end
    end
    checks++;
    if (dir !== 1'b1) begin
      errors++;
      $display("FAIL auto_dir_down got dir=%b want 1", dir);
    end
    // run press, then free-running down pulses
    npulse = 0;
    for (int k = 0; k < 53; k++) begin
      cycle(1'b1, (k < 8) ? 3'b100 : 3'b000);
      if (push == 2'b10) npulse++;
      if (k == 5 || k == 6) begin
        checks++;
        if (run !== 1'(k == 6)) begin
          errors++;
          $display("FAIL auto_run_rise k=%0d got run=%b want %b", k, run, 1'(k == 6));
        end
      end
      checks++;
      if ({push, state, run, dir} !== {m_push, 2'(m_mode), m_run, m_dir}) begin
        errors++;
        $display("FAIL auto_run k=%0d got push=%b state=%b run=%b dir=%b want push=%b state=%0d run=%b dir=%b",
                 k, push, state, run, dir, m_push, m_mode, m_run, m_dir);
      end
    end
    checks++;
    if (npulse != 4) begin
      errors++;
      $display("FAIL auto_pulse_count got %0d want 4", npulse);
    end
    // manual up press mid-run, then auto resumes upward, then stop
    for (int k = 0; k < 92; k++) begin
      cycle(1'b1, (k < 20) ? 3'b001 : (k >= 64 && k < 72) ? 3'b100 : 3'b000);
      checks++;
      if ({push, state, run, dir} !== {m_push, 2'(m_mode), m_run, m_dir}) begin
        errors++;
        $display("FAIL auto_manual k=%0d got push=%b state=%b run=%b dir=%b want push=%b state=%0d run=%b dir=%b",
                 k, push, state, run, dir, m_push, m_mode, m_run, m_dir);
      end
    end
    checks++;
    if (dir !== 1'b0 || run !== 1'b0) begin
      errors++;
      $display("FAIL auto_end got dir=%b run=%b want dir=0 run=0", dir, run);
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic [1:0] exp_p;
    for (int k = 0; k < 30; k++) cycle(1'b1, 3'b001);
    checks++;
    if (state !== 2'b10) begin
      errors++;
      $display("FAIL pre_reset_state got %b want 10", state);
    end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 3'b001);
      checks++;
      if ({push, state, run, dir} !== 6'b0) begin
        errors++;
        $display("FAIL reset_mid k=%0d got push=%b state=%b run=%b dir=%b want all zero", k, push, state, run, dir);
      end
    end
    for (int k = 0; k < 41; k++) begin
      cycle(1'b1, 3'b001);
      exp_p = (k == 6 || k == 22 || k == 30 || k == 38) ? 2'b01 : 2'b00;
      checks++;
      if (push !== exp_p) begin
        errors++;
        $display("FAIL reset_rehold edge %0d got push=%b want %b", k, push, exp_p);
      end
    end
    for (int k = 0; k < 12; k++) cycle(1'b1, 3'b000);
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_state got %b want 00", state);
    end
  endtask

  task automatic test_random();
    logic [2:0] v;
    int         len;
    for (int s = 0; s < 40; s++) begin
      v   = 3'($urandom_range(0, 7));
      len = int'($urandom_range(1, 25));
      if ($urandom_range(0, 19) == 0) begin
        cycle(1'b0, v);
        cycle(1'b0, v);
      end
      for (int k = 0; k < len; k++) begin
        cycle(1'b1, v);
        checks++;
        if ({push, state, run, dir} !== {m_push, 2'(m_mode), m_run, m_dir}) begin
          errors++;
          $display("FAIL random seg=%0d k=%0d got push=%b state=%b run=%b dir=%b want push=%b state=%0d run=%b dir=%b",
                   s, k, push, state, run, dir, m_push, m_mode, m_run, m_dir);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 3'b000;
    test_reset();
    test_clean_hold();
    test_bounce();
    test_simultaneous();
    test_auto_run();
    test_reset_mid_repeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
